// File: rtl/rr_handshake_pkg.sv
// Shared types and constants for the round-robin handshake merge stage.
package rr_handshake_pkg;

  localparam int WIDTH = 4;
  localparam int N     = 3;

  typedef logic [1:0]       src_idx_t;
  typedef logic [WIDTH-1:0] data_t;

  typedef struct packed {
    src_idx_t src;
    data_t    data;
  } entry_t;

  // Lane index (a + b) mod N, valid for a < N and b < N.
  function automatic src_idx_t lane_add(src_idx_t a, src_idx_t b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 3'(N)) sum = sum - 3'(N);
    return sum[1:0];
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO of entry_t with a registered head; the head holds its last value when empty.
module skid_fifo2
  import rr_handshake_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push,
  input  logic       pop,
  input  entry_t     push_entry,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t tail;
  logic   do_push;
  logic   do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // NOTE: sequential state uses non-blocking assignments only, so every read below sees the pre-edge value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: both storage entries are cleared explicitly because the head drives out_data directly after reset.
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_entry;
          else               tail <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: count holds, order is preserved.
          if (count == 2'd1) begin
            head <= push_entry;
          end else begin
            head <= tail;
            tail <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rr_handshake_mux.sv
// Merges three ready/valid lanes round-robin into one channel through a 2-entry buffer,
// tagging each word with its source lane and counting grants per lane.
module rr_handshake_mux
  import rr_handshake_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  output logic [3*8-1:0]       grant_cnt
);

  src_idx_t   ptr;
  src_idx_t   cand;
  logic       cand_vld;
  logic       full;
  logic       push;
  logic       pop;
  logic [1:0] count;
  entry_t     push_entry;
  entry_t     head;
  logic [7:0] cnt [N];

  // Full comes from the registered count only, keeping out_ready off the in_ready path.
  assign full = (count == 2'd2);

  // Search ptr, ptr+1, ptr+2; iterating downwards lets the nearest valid lane win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cand     = '0;
    cand_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[lane_add(ptr, src_idx_t'(k))]) begin
        cand     = lane_add(ptr, src_idx_t'(k));
        cand_vld = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!RESET && !full && cand_vld) in_ready[cand] = 1'b1;
  end

  assign push            = |(in_valid & in_ready);
  assign pop             = out_valid && out_ready;
  assign push_entry.src  = cand;
  assign push_entry.data = in_data[cand*WIDTH +: WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= lane_add(cand, src_idx_t'(1));
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (RESET) begin
        cnt[i] <= '0;
      end else if (push && (cand == src_idx_t'(i)) && (cnt[i] != 8'hFF)) begin
        cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N; i++) grant_cnt[i*8 +: 8] = cnt[i];
  end

  skid_fifo2 u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_data  = head.data;
  assign out_src   = head.src;

endmodule

// File: tb/tb_rr_handshake_mux.sv
// Directed-vector bench for rr_handshake_mux: reset, round-robin, backpressure,
// simultaneous push/pop, mid-operation reset and grant counter saturation.
module tb_rr_handshake_mux;
  import rr_handshake_pkg::*;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic [3*8-1:0]     grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  rr_handshake_mux dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .grant_cnt (grant_cnt)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 3'b111; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL reset_in_ready got %b want 000", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_vec++; if (grant_cnt !== 24'h0) begin n_err++; $display("FAIL reset_grant_cnt got %h want 000000", grant_cnt); end
    RESET = 1'b0; in_valid = 3'b000;
    #1;
    in_valid = 3'b111;
    #1;
    n_vec++; if (in_ready !== 3'b001) begin n_err++; $display("FAIL release_in_ready got %b want 001", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    in_data = {4'h3, 4'h2, 4'h1}; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 3'b001 << (i % 3);
      n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rr_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy); end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'(i % 3) || out_data !== 4'(i % 3 + 1)) begin
        n_err++;
        $display("FAIL rr_out[%0d] got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                 i, out_valid, out_src, out_data, i % 3, i % 3 + 1);
      end
    end
    in_valid = 3'b000;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 3'b010; in_data = {4'h0, 4'hA, 4'h0};
    #1;
    n_vec++; if (in_ready !== 3'b010) begin n_err++; $display("FAIL bp_rdy_a got %b want 010", in_ready); end
    tick();
    in_data = {4'h0, 4'hB, 4'h0};
    #1;
    n_vec++; if (in_ready !== 3'b010 || out_data !== 4'hA) begin n_err++; $display("FAIL bp_rdy_b got rdy=%b data=%h want 010/a", in_ready, out_data); end
    tick();
    in_data = {4'h0, 4'hC, 4'h0};
    #1;
    n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL bp_full got %b want 000", in_ready); end
    tick();
    n_vec++; if (in_ready !== 3'b000 || out_data !== 4'hA) begin n_err++; $display("FAIL bp_hold got rdy=%b data=%h want 000/a", in_ready, out_data); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL bp_no_comb_path got %b want 000", in_ready); end
    tick();
    n_vec++; if (out_data !== 4'hB || in_ready !== 3'b010) begin n_err++; $display("FAIL bp_pop_a got data=%h rdy=%b want b/010", out_data, in_ready); end
    tick();
    in_valid = 3'b000;
    #1;
    n_vec++; if (out_data !== 4'hC || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_pop_b got data=%h v=%b want c/1", out_data, out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_data !== 4'hC) begin n_err++; $display("FAIL bp_empty_hold got v=%b data=%h want 0/c", out_valid, out_data); end
  endtask

  task automatic test_push_pop();
    // ptr is 2 here; lane 2 idle so lane 0 is granted.
    out_ready = 1'b0; in_valid = 3'b001; in_data = {4'h7, 4'h0, 4'h5};
    tick();
    in_valid = 3'b100; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 3'b100 || out_data !== 4'h5) begin n_err++; $display("FAIL pp_setup got rdy=%b data=%h want 100/5", in_ready, out_data); end
    tick();
    in_valid = 3'b000;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 4'h7 || out_src !== 2'd2) begin
      n_err++; $display("FAIL pp_update got v=%b data=%h src=%0d want 1/7/2", out_valid, out_data, out_src);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_count1 got v=%b want 0", out_valid); end
    n_vec++; if (grant_cnt !== 24'h030503) begin n_err++; $display("FAIL grant_totals got %h want 030503", grant_cnt); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 3'b111; in_data = {4'h3, 4'h2, 4'h1};
    tick(); tick();
    n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL mr_full got %b want 000", in_ready); end
    RESET = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL mr_rdy_in_reset got %b want 000", in_ready); end
    tick();
    RESET = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 3'b001) begin
      n_err++; $display("FAIL mr_after got v=%b data=%h rdy=%b want 0/0/001", out_valid, out_data, in_ready);
    end
    tick();
    in_valid = 3'b000;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h1) begin
      n_err++; $display("FAIL mr_first got v=%b src=%0d data=%h want 1/0/1", out_valid, out_src, out_data);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_stale got v=%b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    // Lane 0 already holds one grant from the mid-reset scenario.
    out_ready = 1'b1; in_valid = 3'b001; in_data = {4'h0, 4'h0, 4'h9};
    for (int i = 0; i < 253; i++) tick();
    n_vec++; if (grant_cnt !== 24'h0000FE) begin n_err++; $display("FAIL sat_254 got %h want 0000fe", grant_cnt); end
    for (int i = 0; i < 47; i++) tick();
    n_vec++; if (grant_cnt !== 24'h0000FF) begin n_err++; $display("FAIL sat_300 got %h want 0000ff", grant_cnt); end
    in_valid = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
